// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
//   req_id_t  : requester index (REQ_CPU / REQ_EXT)
//   mem_req_t : one requester's access fields, muxed onto the memory port
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 12;
  localparam int MEM_DATA_W = 16;

  typedef logic req_id_t;

  localparam req_id_t REQ_CPU = 1'b0;
  localparam req_id_t REQ_EXT = 1'b1;

  typedef struct packed {
    logic                  we;
    logic                  lock;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Round-robin / burst-lock grant decision. Purely combinational; the state
// it reads and produces is held by mem_arbiter.
//   req_i/lock_i        : per-requester request and burst-lock
//   last_i              : last granted requester
//   owner_i/locked_i    : current burst owner and whether a lock is active
//   beat_i              : consecutive locked grants so far (saturates)
//   gnt_o               : one-hot grant, zero when idle
//   *_nxt_o             : next-state values for the registers above
module mem_arb_rr
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int BEAT_W    = 3
) (
  input  logic [1:0]        req_i,
  input  logic [1:0]        lock_i,
  input  req_id_t           last_i,
  input  req_id_t           owner_i,
  input  logic              locked_i,
  input  logic [BEAT_W-1:0] beat_i,
  output logic [1:0]        gnt_o,
  output req_id_t           last_nxt_o,
  output req_id_t           owner_nxt_o,
  output logic              locked_nxt_o,
  output logic [BEAT_W-1:0] beat_nxt_o
);

  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(MAX_BURST);

  logic    w_any;
  logic    w_both;
  logic    w_hold;
  req_id_t w_win;

  always_comb begin
    w_any  = |req_i;
    w_both = &req_i;
    // Owner keeps the grant unless its burst budget is spent and the other
    // side is actually waiting.
    w_hold = locked_i && req_i[owner_i] &&
             ((beat_i != BEAT_MAX) || !req_i[~owner_i]);
    // While locked, last_i always equals owner_i, so ~last_i also yields the
    // competitor when the burst budget is exhausted.
    if (w_hold)      w_win = owner_i;
    else if (w_both) w_win = ~last_i;
    else             w_win = req_i[1];

    gnt_o = w_any ? (w_win ? 2'b10 : 2'b01) : 2'b00;

    last_nxt_o   = last_i;
    owner_nxt_o  = owner_i;
    locked_nxt_o = 1'b0;
    beat_nxt_o   = '0;
    if (w_any) begin
      last_nxt_o = w_win;
      if (lock_i[w_win]) begin
        locked_nxt_o = 1'b1;
        owner_nxt_o  = w_win;
        if (locked_i && (owner_i == w_win))
          beat_nxt_o = (beat_i == BEAT_MAX) ? beat_i : beat_i + BEAT_W'(1);
        else
          beat_nxt_o = BEAT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous 16-bit memory.
// One access per cycle; round-robin with bounded burst lock; read data is
// returned one cycle after the grant, qualified by the issuing requester's
// rvalid.
//   clk_i/rst_i          : clock, synchronous active-high reset
//   rN_req/we/lock/addr/wdata_i : requester N access
//   rN_gnt_o             : combinational grant
//   rN_rdata_o/rvalid_o  : read return (rdata shared, rvalid qualified)
//   mem_*                : memory port (addr, din, dout, enables)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = MEM_ADDR_W,
  parameter int DATA_WIDTH = MEM_DATA_W,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  r0_req_i,
  input  logic                  r0_we_i,
  input  logic                  r0_lock_i,
  input  logic [ADDR_WIDTH-1:0] r0_addr_i,
  input  logic [DATA_WIDTH-1:0] r0_wdata_i,
  output logic                  r0_gnt_o,
  output logic [DATA_WIDTH-1:0] r0_rdata_o,
  output logic                  r0_rvalid_o,
  input  logic                  r1_req_i,
  input  logic                  r1_we_i,
  input  logic                  r1_lock_i,
  input  logic [ADDR_WIDTH-1:0] r1_addr_i,
  input  logic [DATA_WIDTH-1:0] r1_wdata_i,
  output logic                  r1_gnt_o,
  output logic [DATA_WIDTH-1:0] r1_rdata_o,
  output logic                  r1_rvalid_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_value_o,
  input  logic [DATA_WIDTH-1:0] mem_value_i,
  output logic                  mem_enable_o,
  output logic                  mem_rd_en_o,
  output logic                  mem_wr_en_o
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  req_id_t           r_last;
  req_id_t           r_owner;
  logic              r_locked;
  logic [BEAT_W-1:0] r_beat;
  logic              r_rd_pend;
  req_id_t           r_rd_owner;

  mem_req_t [1:0]    w_req;
  logic [1:0]        w_req_v;
  logic [1:0]        w_gnt;
  logic              w_any;
  req_id_t           w_idx;
  req_id_t           w_last_nxt;
  req_id_t           w_owner_nxt;
  logic              w_locked_nxt;
  logic [BEAT_W-1:0] w_beat_nxt;

  assign w_req[0] = '{we: r0_we_i, lock: r0_lock_i, addr: r0_addr_i, wdata: r0_wdata_i};
  assign w_req[1] = '{we: r1_we_i, lock: r1_lock_i, addr: r1_addr_i, wdata: r1_wdata_i};

  // Requests are masked during reset so nothing reaches the memory.
  assign w_req_v = {r1_req_i, r0_req_i} & {2{~rst_i}};

  mem_arb_rr #(.MAX_BURST(MAX_BURST), .BEAT_W(BEAT_W)) u_rr (
    .req_i        (w_req_v),
    .lock_i       ({w_req[1].lock, w_req[0].lock}),
    .last_i       (r_last),
    .owner_i      (r_owner),
    .locked_i     (r_locked),
    .beat_i       (r_beat),
    .gnt_o        (w_gnt),
    .last_nxt_o   (w_last_nxt),
    .owner_nxt_o  (w_owner_nxt),
    .locked_nxt_o (w_locked_nxt),
    .beat_nxt_o   (w_beat_nxt)
  );

  assign w_any = |w_gnt;
  assign w_idx = w_gnt[1];

  assign r0_gnt_o     = w_gnt[0];
  assign r1_gnt_o     = w_gnt[1];
  assign mem_addr_o   = w_req[w_idx].addr;
  assign mem_value_o  = w_req[w_idx].wdata;
  assign mem_enable_o = w_any;
  assign mem_rd_en_o  = w_any & ~w_req[w_idx].we;
  assign mem_wr_en_o  = w_any &  w_req[w_idx].we;

  // Memory dout is broadcast; only rvalid tells who owns it.
  assign r0_rdata_o  = mem_value_i;
  assign r1_rdata_o  = mem_value_i;
  assign r0_rvalid_o = r_rd_pend & ~rst_i & (r_rd_owner == REQ_CPU);
  assign r1_rvalid_o = r_rd_pend & ~rst_i & (r_rd_owner == REQ_EXT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last     <= REQ_EXT;
      r_owner    <= REQ_CPU;
      r_locked   <= 1'b0;
      r_beat     <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= REQ_CPU;
    end else begin
      r_last     <= w_last_nxt;
      r_owner    <= w_owner_nxt;
      r_locked   <= w_locked_nxt;
      r_beat     <= w_beat_nxt;
      r_rd_pend  <= w_any & ~w_req[w_idx].we;
      r_rd_owner <= w_idx;
    end
  end

endmodule
